// File: rtl/uart_tx_arbiter_if.sv
// Request and UART-side signals for the two-port UART transmit arbiter.
// master = requesters plus UART; slave = the arbiter itself.
interface uart_tx_arbiter_if;
  logic        a_valid;
  logic        a_ready;
  logic [31:0] a_data;
  logic [1:0]  a_len;
  logic        b_valid;
  logic        b_ready;
  logic [31:0] b_data;
  logic [1:0]  b_len;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_byte;

  modport master (
    output a_valid, a_data, a_len, b_valid, b_data, b_len, tx_busy,
    input  a_ready, b_ready, tx_start, tx_byte
  );

  modport slave (
    input  a_valid, a_data, a_len, b_valid, b_data, b_len, tx_busy,
    output a_ready, b_ready, tx_start, tx_byte
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between two requesters.
// Each accepted word is sent as a header byte followed by 1-4 payload bytes, LSB first.
module uart_tx_arbiter #(
  parameter int unsigned START_TIMEOUT = 16
) (
  input  logic                clock,
  input  logic                reset,
  uart_tx_arbiter_if.slave    bus,
  output logic                busy,
  output logic                grant_id,
  output logic                err_timeout,
  input  logic                err_clear
);

  typedef enum logic [1:0] {StIdle, StStart, StAck, StDone} state_e;

  localparam logic [7:0] TmoLast = 8'(START_TIMEOUT - 1);

  state_e      state_q;
  logic        last_grant_q;
  logic        grant_id_q;
  logic        err_q;
  logic [31:0] data_q;
  logic [1:0]  len_q;
  logic [2:0]  byte_idx_q;
  logic [7:0]  tmo_cnt_q;
  logic [7:0]  tx_byte_q;

  logic       grant_a;
  logic       grant_b;
  logic       idle;
  logic [2:0] pay_idx;
  logic [7:0] cur_byte;
  logic       last_byte;

  // Tie goes to whichever port did not win last time.
  assign grant_a = bus.a_valid & (~bus.b_valid | last_grant_q);
  assign grant_b = bus.b_valid & (~bus.a_valid | ~last_grant_q);
  assign idle    = (state_q == StIdle) & ~reset;

  assign bus.a_ready = idle & grant_a;
  assign bus.b_ready = idle & grant_b;

  assign pay_idx   = byte_idx_q - 3'd1;
  assign last_byte = (byte_idx_q == ({1'b0, len_q} + 3'd1));

  always_comb begin
    cur_byte = {1'b1, grant_id_q, 4'b0000, len_q};
    if (byte_idx_q != 3'd0) begin
      unique case (pay_idx[1:0])
        2'd0: cur_byte = data_q[7:0];
        2'd1: cur_byte = data_q[15:8];
        2'd2: cur_byte = data_q[23:16];
        2'd3: cur_byte = data_q[31:24];
        default: cur_byte = data_q[7:0];
      endcase
    end
  end

  // Pulse is issued in the START cycle itself so the header can go out at T+1.
  assign bus.tx_start = (state_q == StStart) & ~bus.tx_busy & ~reset;
  assign bus.tx_byte  = bus.tx_start ? cur_byte : tx_byte_q;

  assign busy        = (state_q != StIdle);
  assign grant_id    = grant_id_q;
  assign err_timeout = err_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
      err_q        <= 1'b0;
      data_q       <= '0;
      len_q        <= '0;
      byte_idx_q   <= '0;
      tmo_cnt_q    <= '0;
      tx_byte_q    <= '0;
    end else begin
      if (err_clear) err_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.a_ready || bus.b_ready) begin
            data_q       <= bus.b_ready ? bus.b_data : bus.a_data;
            len_q        <= bus.b_ready ? bus.b_len : bus.a_len;
            grant_id_q   <= bus.b_ready;
            last_grant_q <= bus.b_ready;
            byte_idx_q   <= 3'd0;
            state_q      <= StStart;
          end
        end
        StStart: begin
          if (!bus.tx_busy) begin
            tx_byte_q <= cur_byte;
            tmo_cnt_q <= 8'd0;
            state_q   <= StAck;
          end
        end
        StAck: begin
          if (bus.tx_busy) begin
            state_q <= StDone;
          end else if (tmo_cnt_q == TmoLast) begin
            // Overrides a same-cycle err_clear.
            err_q   <= 1'b1;
            state_q <= StIdle;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
          end
        end
        StDone: begin
          if (!bus.tx_busy) begin
            if (last_byte) begin
              state_q <= StIdle;
            end else begin
              byte_idx_q <= byte_idx_q + 3'd1;
              state_q    <= StStart;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
